// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses and operand-select encodings shared by the decoder and csr_unit
package csr_pkg;
  localparam logic [11:0] CSR_TOHOST  = 12'h51E;
  localparam logic [11:0] CSR_CYCLE   = 12'hC00;
  localparam logic [11:0] CSR_INSTRET = 12'hC02;
  localparam logic [2:0]  CSR_SEL_RS1 = 3'b000;
  localparam logic [2:0]  CSR_SEL_IMM = 3'b001;
endpackage

// File: rtl/csr_counter.sv
// csr_counter: wrapping up-counter with sync clear (priority over inc) and async reset
// ports: clk, rst (async, active-high), clr, inc -> count[WIDTH-1:0]
module csr_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + WIDTH'(1);
endmodule

// File: rtl/csr_unit.sv
// csr_unit: tohost register plus cycle/instret counters with a combinational CSR read port
// ports: clk, rst (async, active-high), inst_valid, stall, csr_wen, csr_sel[2:0],
//   csr_addr[11:0], rs1_data[31:0], zimm[4:0], retire, cnt_rst
//   -> csr_rdata[31:0] (read-before-write), tohost[31:0], tohost_wr (one-cycle pulse)
// build option: CSR_INSTRET_EN includes the instret counter at 0xC02
module csr_unit
  import csr_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic        stall,
  input  logic        csr_wen,
  input  logic [2:0]  csr_sel,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  input  logic        retire,
  input  logic        cnt_rst,
  output logic [31:0] csr_rdata,
  output logic [31:0] tohost,
  output logic        tohost_wr
);
  logic                 commit;
  logic                 tohost_hit;
  logic [31:0]          wdata;
  logic [CNT_WIDTH-1:0] cycle;
  logic [31:0]          instret_rd;
  logic                 unused_sel;
  assign commit     = csr_wen & inst_valid & ~stall;
  assign tohost_hit = commit && csr_addr == CSR_TOHOST;
  assign wdata      = csr_sel[0] == CSR_SEL_IMM[0] ? {27'b0, zimm} : rs1_data;
  assign unused_sel = ^{csr_sel[2:1], CSR_SEL_RS1};
  csr_counter #(.WIDTH(CNT_WIDTH)) u_cycle (
    .clk(clk), .rst(rst), .clr(cnt_rst), .inc(1'b1), .count(cycle)
  );
`ifdef CSR_INSTRET_EN
  logic [CNT_WIDTH-1:0] instret;
  csr_counter #(.WIDTH(CNT_WIDTH)) u_instret (
    .clk(clk), .rst(rst), .clr(cnt_rst), .inc(retire), .count(instret)
  );
  assign instret_rd = 32'(instret);
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instret_rd    = '0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tohost    <= '0;
      tohost_wr <= 1'b0;
    end else begin
      tohost_wr <= tohost_hit;
      if (tohost_hit) tohost <= wdata;
    end
  // read-only CSRs simply never appear on the write path; unknown addresses read 0
  always_comb
    csr_rdata = csr_addr == CSR_TOHOST  ? tohost :
                csr_addr == CSR_CYCLE   ? 32'(cycle) :
                csr_addr == CSR_INSTRET ? instret_rd : 32'b0;
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed scoreboard bench for csr_unit (32-bit counters plus a 4-bit wrap instance)
module tb_csr_unit;
  import csr_pkg::*;
`ifdef CSR_INSTRET_EN
  localparam bit IE = 1'b1;
`else
  localparam bit IE = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0, stall = 1'b0, csr_wen = 1'b0, retire = 1'b0, cnt_rst = 1'b0;
  logic [2:0]  csr_sel = 3'b0;
  logic [11:0] csr_addr = 12'h0;
  logic [31:0] rs1_data = 32'h0;
  logic [4:0]  zimm = 5'h0;
  logic [31:0] csr_rdata, tohost, csr_rdata4, tohost4;
  logic        tohost_wr, tohost_wr4;
  typedef struct {string tag; logic [31:0] val;} exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  csr_unit dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .stall(stall), .csr_wen(csr_wen),
    .csr_sel(csr_sel), .csr_addr(csr_addr), .rs1_data(rs1_data), .zimm(zimm),
    .retire(retire), .cnt_rst(cnt_rst), .csr_rdata(csr_rdata), .tohost(tohost),
    .tohost_wr(tohost_wr)
  );
  csr_unit #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .stall(stall), .csr_wen(csr_wen),
    .csr_sel(csr_sel), .csr_addr(csr_addr), .rs1_data(rs1_data), .zimm(zimm),
    .retire(retire), .cnt_rst(cnt_rst), .csr_rdata(csr_rdata4), .tohost(tohost4),
    .tohost_wr(tohost_wr4)
  );

  task automatic push(input string tag, input logic [31:0] val);
    exp_q.push_back('{tag, val});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: observed %h with no expected value", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] v);
    csr_addr = a;
    push(tag, v);
    #1 check(csr_rdata);
  endtask

  initial begin
    #12;
    push("reset_tohost", 32'h0);    check(tohost);
    push("reset_tohost_wr", 32'h0); check({31'b0, tohost_wr});
    @(negedge clk);
    rst = 1'b0;
    rd("cycle_first", CSR_CYCLE, 32'd0);
    for (int i = 0; i < 10; i++) begin
      retire = i < 4;
      step();
    end
    retire = 1'b0;
    rd("cycle_10", CSR_CYCLE, 32'd10);
    rd("instret_4", CSR_INSTRET, IE ? 32'd4 : 32'd0);
    csr_addr = CSR_CYCLE; csr_wen = 1'b1; inst_valid = 1'b1; csr_sel = CSR_SEL_RS1; rs1_data = 32'h1234;
    step();
    csr_wen = 1'b0;
    rd("cycle_ro", CSR_CYCLE, 32'd11);
    push("ro_tohost_wr", 32'h0); check({31'b0, tohost_wr});
    rd("unknown_addr", 12'h300, 32'h0);
    cnt_rst = 1'b1; retire = 1'b1;
    step();
    cnt_rst = 1'b0; retire = 1'b0;
    rd("clr_cycle", CSR_CYCLE, 32'd0);
    rd("clr_instret", CSR_INSTRET, 32'd0);
    retire = 1'b1;
    step();
    retire = 1'b0;
    rd("inc_cycle", CSR_CYCLE, 32'd1);
    rd("inc_instret", CSR_INSTRET, IE ? 32'd1 : 32'd0);
    step(16);
    rd("cycle_17", CSR_CYCLE, 32'd17);
    push("wrap4_cycle", 32'd1); check(csr_rdata4);
    csr_addr = CSR_TOHOST; csr_wen = 1'b1; csr_sel = CSR_SEL_IMM; zimm = 5'd17;
    rd("rbw_old", CSR_TOHOST, 32'h0);
    step();
    csr_wen = 1'b0;
    push("imm_tohost", 32'd17);  check(tohost);
    push("imm_wr_pulse", 32'h1); check({31'b0, tohost_wr});
    rd("imm_read", CSR_TOHOST, 32'd17);
    step();
    push("imm_wr_end", 32'h0);   check({31'b0, tohost_wr});
    csr_wen = 1'b1; csr_sel = CSR_SEL_RS1; rs1_data = 32'hDEADBEEF; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      push("stall_tohost", 32'd17); check(tohost);
      push("stall_wr", 32'h0);      check({31'b0, tohost_wr});
    end
    stall = 1'b0;
    step();
    csr_wen = 1'b0;
    push("unstall_tohost", 32'hDEADBEEF); check(tohost);
    push("unstall_wr", 32'h1);            check({31'b0, tohost_wr});
    csr_wen = 1'b1; inst_valid = 1'b0; rs1_data = 32'hCAFE;
    step(2);
    push("bubble_tohost", 32'hDEADBEEF); check(tohost);
    push("bubble_wr", 32'h0);            check({31'b0, tohost_wr});
    inst_valid = 1'b1; csr_sel = CSR_SEL_IMM; zimm = 5'd5;
    step();
    push("b2b_first", 32'd5);  check(tohost);
    push("b2b_wr1", 32'h1);    check({31'b0, tohost_wr});
    csr_sel = CSR_SEL_RS1; rs1_data = 32'h55;
    step();
    push("b2b_second", 32'h55); check(tohost);
    push("b2b_wr2", 32'h1);     check({31'b0, tohost_wr});
    // reset lands between edges while another commit is still being requested
    #2 rst = 1'b1;
    #1;
    push("arst_tohost", 32'h0); check(tohost);
    push("arst_wr", 32'h0);     check({31'b0, tohost_wr});
    rd("arst_cycle", CSR_CYCLE, 32'h0);
    rd("arst_instret", CSR_INSTRET, 32'h0);
    push("arst_cycle4", 32'h0); check(csr_rdata4);
    csr_wen = 1'b0;
    @(negedge clk);
    push("arst_hold", 32'h0); check(tohost);
    rst = 1'b0;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: %0d expected values unchecked", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
